// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use bubbles, branch flushes, mul/div
// occupancy and data-memory freeze. Define HAZARD_PERF_CNT_EN to add performance counters.
module hazard_sequencer #(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] rd_ex,
  input  logic       load_ex,
  input  logic       branch_taken_ex,
  input  logic       md_start_ex,
  input  logic       md_done,
  input  logic       dmem_ready,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_if,
  output logic       md_abort,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cycles,
  output logic [31:0] perf_md_cycles,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {StRun, StLuStall, StMdWait} state_e;

  localparam logic [2:0] LuInit  = 3'(LU_BUBBLES - 1);
  localparam logic [7:0] MdLimit = 8'(MD_TIMEOUT);

  state_e     state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       lu_hit;

  assign lu_hit = load_ex && (rd_ex != 5'd0) &&
                  ((use_rs1_id && (rs1_id == rd_ex)) || (use_rs2_id && (rs2_id == rd_ex)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      lu_cnt_q <= 3'd0;
      md_cnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    md_cnt_d = md_cnt_q;
    if (dmem_ready) begin
      unique case (state_q)
        StRun: begin
          if (md_start_ex) begin
            state_d  = StMdWait;
            md_cnt_d = 8'd1;
          end else if (branch_taken_ex) begin
            state_d = StRun;
          end else if (lu_hit && (LU_BUBBLES > 1)) begin
            state_d  = StLuStall;
            lu_cnt_d = LuInit;
          end
        end
        StLuStall: begin
          lu_cnt_d = lu_cnt_q - 3'd1;
          if (lu_cnt_q <= 3'd1) state_d = StRun;
        end
        StMdWait: begin
          if (md_cnt_q != 8'hff) md_cnt_d = md_cnt_q + 8'd1;
          if (md_done || (md_cnt_q == MdLimit)) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    md_abort  = 1'b0;
    busy      = 1'b0;
    if (rst_n) begin
      busy = (state_q != StRun);
      if (!dmem_ready) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else begin
        unique case (state_q)
          StRun: begin
            if (md_start_ex) begin
              stall_if = 1'b1;
              stall_id = 1'b1;
              flush_ex = 1'b1;
            end else if (branch_taken_ex) begin
              flush_if = 1'b1;
              flush_id = 1'b1;
            end else if (lu_hit) begin
              stall_if = 1'b1;
              stall_id = 1'b1;
              flush_id = 1'b1;
            end
          end
          StLuStall: begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_id = 1'b1;
          end
          StMdWait: begin
            // md_done lets the result advance; on timeout the held mul/div is bubbled out
            if (!md_done) begin
              flush_ex = 1'b1;
              if (md_cnt_q == MdLimit) begin
                md_abort = 1'b1;
                flush_id = 1'b1;
              end else begin
                stall_if = 1'b1;
                stall_id = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic lu_evt, md_evt, br_evt;

  assign lu_evt = dmem_ready && ((state_q == StLuStall) ||
                  ((state_q == StRun) && !md_start_ex && !branch_taken_ex && lu_hit));
  assign md_evt = dmem_ready && (state_q == StMdWait);
  assign br_evt = dmem_ready && (state_q == StRun) && !md_start_ex && branch_taken_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_lu_cycles <= 32'd0;
      perf_md_cycles <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (lu_evt) perf_lu_cycles <= perf_lu_cycles + 32'd1;
      if (md_evt) perf_md_cycles <= perf_md_cycles + 32'd1;
      if (br_evt) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized scoreboard bench for hazard_sequencer: two instances (1 bubble / timeout 64 and
// 3 bubbles / timeout 4) share stimulus and are checked against a cycle-level reference model.
module tb_hazard_sequencer;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, load, br, mds, mdd, rdy;
  } stim_t;

  typedef struct {
    int lu_left;
    bit md_on;
    int md_age;
  } mstate_t;

  typedef struct {
    int         idx;
    logic [8:0] ea;
    logic [8:0] eb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, use_rs1_id, use_rs2_id, load_ex, branch_taken_ex, md_start_ex, md_done;
  logic       dmem_ready;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic [8:0] out_a, out_b;

  exp_t    q[$];
  mstate_t ma, mb;
  int      n_applied = 0;
  int      n_miss = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] plu_a, pmd_a, pfl_a, plu_b, pmd_b, pfl_b;
`endif

  hazard_sequencer #(.LU_BUBBLES(1), .MD_TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id),
    .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .load_ex(load_ex), .branch_taken_ex(branch_taken_ex),
    .md_start_ex(md_start_ex), .md_done(md_done), .dmem_ready(dmem_ready),
    .stall_if(out_a[8]), .stall_id(out_a[7]), .stall_ex(out_a[6]), .stall_mem(out_a[5]),
    .flush_if(out_a[4]), .flush_id(out_a[3]), .flush_ex(out_a[2]), .md_abort(out_a[1]),
    .busy(out_a[0])
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cycles(plu_a), .perf_md_cycles(pmd_a), .perf_flush_cnt(pfl_a)
`endif
  );

  hazard_sequencer #(.LU_BUBBLES(3), .MD_TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id),
    .use_rs2_id(use_rs2_id), .rd_ex(rd_ex), .load_ex(load_ex), .branch_taken_ex(branch_taken_ex),
    .md_start_ex(md_start_ex), .md_done(md_done), .dmem_ready(dmem_ready),
    .stall_if(out_b[8]), .stall_id(out_b[7]), .stall_ex(out_b[6]), .stall_mem(out_b[5]),
    .flush_if(out_b[4]), .flush_id(out_b[3]), .flush_ex(out_b[2]), .md_abort(out_b[1]),
    .busy(out_b[0])
`ifdef HAZARD_PERF_CNT_EN
    , .perf_lu_cycles(plu_b), .perf_md_cycles(pmd_b), .perf_flush_cnt(pfl_b)
`endif
  );

  // Reference: lu_left = bubbles still owed, md_age = cycles the mul/div has been waiting.
  function automatic void model(input stim_t s, input int lub, input int mto,
                                input mstate_t cur, output logic [8:0] o, output mstate_t nxt);
    logic si, sd, se, sm, fi, fd, fe, ab, bz;
    bit   hit;
    {si, sd, se, sm, fi, fd, fe, ab, bz} = '0;
    nxt = cur;
    hit = s.load && (s.rd != 0) &&
          ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    if (!s.rst_n) begin
      nxt.lu_left = 0;
      nxt.md_on   = 0;
      nxt.md_age  = 0;
    end else begin
      bz = (cur.lu_left > 0) || cur.md_on;
      if (!s.rdy) begin
        {si, sd, se, sm} = 4'hf;
      end else if (cur.md_on) begin
        if (s.mdd) begin
          nxt.md_on = 0;
        end else if (cur.md_age == mto) begin
          ab = 1; fd = 1; fe = 1;
          nxt.md_on = 0;
        end else begin
          si = 1; sd = 1; fe = 1;
          nxt.md_age = (cur.md_age < 255) ? cur.md_age + 1 : 255;
        end
      end else if (cur.lu_left > 0) begin
        si = 1; sd = 1; fd = 1;
        nxt.lu_left = cur.lu_left - 1;
      end else if (s.mds) begin
        si = 1; sd = 1; fe = 1;
        nxt.md_on  = 1;
        nxt.md_age = 1;
      end else if (s.br) begin
        fi = 1; fd = 1;
      end else if (hit) begin
        si = 1; sd = 1; fd = 1;
        nxt.lu_left = lub - 1;
      end
    end
    o = {si, sd, se, sm, fi, fd, fe, ab, bz};
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    s.rdy   = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t    e;
    mstate_t na, nb;
    @(negedge clk);
    rst_n = s.rst_n; rs1_id = s.rs1; rs2_id = s.rs2; rd_ex = s.rd;
    use_rs1_id = s.use1; use_rs2_id = s.use2; load_ex = s.load;
    branch_taken_ex = s.br; md_start_ex = s.mds; md_done = s.mdd; dmem_ready = s.rdy;
    model(s, 1, 64, ma, e.ea, na);
    model(s, 3, 4, mb, e.eb, nb);
    e.idx = n_applied;
    q.push_back(e);
    ma = na;
    mb = nb;
    n_applied++;
  endtask

  // Monitor: outputs are valid every cycle, sampled well after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (out_a !== e.ea) begin
          n_miss++;
          $display("FAIL dut_a vec %0d: got %b want %b", e.idx, out_a, e.ea);
        end
        if (out_b !== e.eb) begin
          n_miss++;
          $display("FAIL dut_b vec %0d: got %b want %b", e.idx, out_b, e.eb);
        end
      end
    end
  end

  initial begin
    stim_t s;
    ma = '{0, 0, 0};
    mb = '{0, 0, 0};

    s = idle(); s.rst_n = 1'b0;
    apply(s); apply(s);
    s = idle();
    repeat (2) apply(s);

    // Load-use on rs2, then the same with rd=x0
    s = idle(); s.load = 1; s.rd = 5; s.rs2 = 5; s.use2 = 1;
    apply(s);
    s = idle(); repeat (4) apply(s);
    s = idle(); s.load = 1; s.rd = 0; s.rs2 = 0; s.use2 = 1;
    apply(s);
    s = idle(); repeat (2) apply(s);

    // mul/div beats branch; md_done five cycles after start
    s = idle(); s.mds = 1; s.br = 1;
    apply(s);
    s = idle(); repeat (4) apply(s);
    s.mdd = 1; apply(s);
    s = idle(); repeat (2) apply(s);

    // No md_done: short-timeout instance aborts
    s = idle(); s.mds = 1;
    apply(s);
    s = idle(); repeat (6) apply(s);
    s.mdd = 1; apply(s);
    s = idle(); apply(s);

    // Freeze for three cycles mid-wait delays the timeout
    s = idle(); s.mds = 1;
    apply(s);
    s = idle(); apply(s);
    s.rdy = 0; repeat (3) apply(s);
    s = idle(); repeat (5) apply(s);
    s.mdd = 1; apply(s);
    s = idle(); apply(s);

    // Reset while the 3-bubble instance is in its stall sequence
    s = idle(); s.load = 1; s.rd = 7; s.rs1 = 7; s.use1 = 1;
    apply(s);
    s = idle(); apply(s);
    s.rst_n = 0; apply(s);
`ifdef HAZARD_PERF_CNT_EN
    @(posedge clk); #1;
    if ({plu_a, pmd_a, pfl_a, plu_b, pmd_b, pfl_b} !== '0) begin
      n_miss++;
      $display("FAIL perf_reset: got %h %h %h %h %h %h want 0", plu_a, pmd_a, pfl_a,
               plu_b, pmd_b, pfl_b);
    end
`endif
    s = idle(); repeat (2) apply(s);

    repeat (3000) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.rdy   = ($urandom_range(0, 99) < 88);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.use1  = ($urandom_range(0, 1) == 1);
      s.use2  = ($urandom_range(0, 1) == 1);
      s.load  = ($urandom_range(0, 99) < 40);
      s.br    = ($urandom_range(0, 99) < 15);
      s.mds   = ($urandom_range(0, 99) < 8);
      s.mdd   = ($urandom_range(0, 99) < 8);
      apply(s);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule
